// File: rtl/lava_sequencer.sv
// Program sequencer for the LAVA datapath: fetches 36-bit ROM words, issues two ALU
// operations per word to a shared ALU, and writes the delayed results to consecutive RAM addresses.
module lava_sequencer #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int ALU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [35:0]       rom_data,
    output logic [3:0]        alu_inst,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic [ADDR_W:0]   ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_ISSUE0 = 3'd2;
    localparam logic [2:0] S_ISSUE1 = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int              LEN_W   = ADDR_W + 1;
    localparam int              CNT_W   = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(ALU_LAT - 1);

    logic [2:0]         state_q,    state_d;
    logic [ADDR_W-1:0]  idx_q,      idx_d;
    logic [LEN_W-1:0]   len_q,      len_d;
    logic [15:0]        word_q,     word_d;
    logic [3:0]         alu_inst_q, alu_inst_d;
    logic [DATA_W-1:0]  alu_a_q,    alu_a_d;
    logic [DATA_W-1:0]  alu_b_q,    alu_b_d;
    logic [ALU_LAT-1:0] pipe_q,     pipe_d;
    logic [LEN_W-1:0]   waddr_q,    waddr_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               issue_s;
    logic [LEN_W-1:0]   len_clamp_s;

    assign len_clamp_s = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
    // A write is due when the issue-valid bit reaches the end of the latency pipe.
    assign ram_we    = pipe_q[ALU_LAT-1];
    assign ram_wdata = alu_result;
    assign ram_waddr = waddr_q;
    assign rom_addr  = idx_q;
    assign alu_inst  = alu_inst_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Next-state, operand and write-tracking logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        word_d     = word_q;
        alu_inst_d = alu_inst_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        cnt_d      = cnt_q;
        issue_s    = 1'b0;
        if (ram_we) begin
            waddr_d = waddr_q + LEN_W'(1);
        end else begin
            waddr_d = waddr_q;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len_clamp_s;
                    idx_d   = '0;
                    waddr_d = '0;
                    if (len_clamp_s != '0) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                // First operation goes straight to the ALU registers; the second half waits in word_q.
                word_d     = rom_data[35:20];
                alu_inst_d = rom_data[19:16];
                alu_a_d    = DATA_W'(rom_data[15:8]);
                alu_b_d    = DATA_W'(rom_data[7:0]);
                state_d    = S_ISSUE0;
            end
            S_ISSUE0: begin
                issue_s = 1'b1;
                alu_a_d = DATA_W'(word_q[15:8]);
                alu_b_d = DATA_W'(word_q[7:0]);
                state_d = S_ISSUE1;
            end
            S_ISSUE1: begin
                issue_s = 1'b1;
                if ({1'b0, idx_q} == (len_q - LEN_W'(1))) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_END) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        pipe_d    = pipe_q << 1;
        pipe_d[0] = issue_s;
        busy_d    = (state_d == S_FETCH) || (state_d == S_ISSUE0) ||
                    (state_d == S_ISSUE1) || (state_d == S_DRAIN);
        done_d    = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            word_q     <= 16'h0000;
            alu_inst_q <= 4'h0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            pipe_q     <= '0;
            waddr_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            word_q     <= word_d;
            alu_inst_q <= alu_inst_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            pipe_q     <= pipe_d;
            waddr_q    <= waddr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_lava_sequencer.sv
// Bench for lava_sequencer: behavioural ROM/ALU/RAM around the DUT and a timing model
// derived from the run rules (per-cycle expected writes, busy and done).
module tb_lava_sequencer;

    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 8;
    localparam int ALU_LAT = 2;
    localparam int NCYC    = 40;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   prog_len;
    logic [ADDR_W-1:0] rom_addr;
    logic [35:0]       rom_data;
    logic [3:0]        alu_inst;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [ADDR_W:0]   ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we, busy, done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [35:0] rom [0:7];
    logic [7:0]  ram [0:15];
    logic [7:0]  alu_pipe [0:ALU_LAT-1];

    bit          exp_we   [0:NCYC-1];
    logic [3:0]  exp_addr [0:NCYC-1];
    logic [7:0]  exp_data [0:NCYC-1];
    bit          exp_busy [0:NCYC-1];
    bit          exp_done [0:NCYC-1];

    lava_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .alu_inst(alu_inst), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign rom_data   = rom[rom_addr];
    assign alu_result = alu_pipe[ALU_LAT-1];

    // ALU with fixed latency, plus a RAM capturing every write.
    always @(posedge clk) begin
        alu_pipe[0] <= alu_f(alu_inst, alu_a, alu_b);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
        if (ram_we) ram[ram_waddr] <= ram_wdata;
    end

    task automatic build_expect(input int plen);
        int n;
        int c;
        n = (plen > 8) ? 8 : plen;
        for (int i = 0; i < NCYC; i++) begin
            exp_we[i] = 1'b0; exp_addr[i] = 4'd0; exp_data[i] = 8'd0;
            exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            c = 2 + 3 * k + ALU_LAT;
            exp_we[c]   = 1'b1;
            exp_addr[c] = 4'(2 * k);
            exp_data[c] = alu_f(rom[k][19:16], rom[k][15:8], rom[k][7:0]);
            exp_we[c+1]   = 1'b1;
            exp_addr[c+1] = 4'(2 * k + 1);
            exp_data[c+1] = alu_f(rom[k][19:16], rom[k][35:28], rom[k][27:20]);
        end
        if (n == 0) begin
            exp_done[1] = 1'b1;
        end else begin
            exp_done[3 * n + ALU_LAT + 1] = 1'b1;
            for (int i = 1; i <= 3 * n + ALU_LAT; i++) exp_busy[i] = 1'b1;
        end
    endtask

    task automatic run_check(input int plen, input bit restart, output int writes);
        build_expect(plen);
        writes = 0;
        @(posedge clk); #1;
        start = 1'b1;
        prog_len = 4'(plen);
        for (int rel = 0; rel < NCYC; rel++) begin
            @(negedge clk);
            tests_run++;
            if (ram_we !== exp_we[rel]) begin
                tests_failed++;
                $display("FAIL ram_we len=%0d cyc=%0d got=%b exp=%b", plen, rel, ram_we, exp_we[rel]);
            end
            if (exp_we[rel]) begin
                tests_run++;
                if (ram_waddr !== exp_addr[rel] || ram_wdata !== exp_data[rel]) begin
                    tests_failed++;
                    $display("FAIL write len=%0d cyc=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                             plen, rel, ram_waddr, ram_wdata, exp_addr[rel], exp_data[rel]);
                end
            end
            if (ram_we === 1'b1) writes++;
            tests_run++;
            if (done !== exp_done[rel] || busy !== exp_busy[rel]) begin
                tests_failed++;
                $display("FAIL done_busy len=%0d cyc=%0d got done=%b busy=%b exp done=%b busy=%b",
                         plen, rel, done, busy, exp_done[rel], exp_busy[rel]);
            end
            if (plen == 0) begin
                tests_run++;
                if (rom_addr !== 3'd0) begin
                    tests_failed++;
                    $display("FAIL rom_addr_len0 cyc=%0d got=%0d exp=0", rel, rom_addr);
                end
            end
            @(posedge clk); #1;
            if (rel == 0) start = 1'b0;
            if (restart && rel == 4) begin
                start = 1'b1;
                prog_len = 4'($urandom_range(0, 15));
            end
            if (restart && rel == 5) start = 1'b0;
        end
    endtask

    task automatic check_writes(input string name, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s write_count got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic load_pattern_rom();
        for (int k = 0; k < 8; k++)
            rom[k] = {8'(k + 16), 8'd1, 4'd0, 8'(k), 8'd1};
    endtask

    task automatic load_random_rom();
        for (int k = 0; k < 8; k++)
            rom[k] = {8'($urandom), 8'($urandom), 4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)};
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; prog_len = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (rom_addr !== 3'd0 || alu_inst !== 4'd0 || alu_a !== 8'd0 || alu_b !== 8'd0 ||
            ram_waddr !== 4'd0 || ram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state got rom=%0d inst=%0d a=%h b=%h waddr=%0d we=%b busy=%b done=%b exp all zero",
                     rom_addr, alu_inst, alu_a, alu_b, ram_waddr, ram_we, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_baseline();
        int w;
        load_pattern_rom();
        run_check(8, 1'b0, w);
        check_writes("baseline", w, 16);
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (ram[2*k] !== 8'(k + 1) || ram[2*k+1] !== 8'(k + 17)) begin
                tests_failed++;
                $display("FAIL baseline_ram k=%0d got %h/%h exp %h/%h",
                         k, ram[2*k], ram[2*k+1], 8'(k + 1), 8'(k + 17));
            end
        end
    endtask

    task automatic test_len1();
        int w;
        load_random_rom();
        run_check(1, 1'b0, w);
        check_writes("len1", w, 2);
    endtask

    task automatic test_len0();
        int w;
        run_check(0, 1'b0, w);
        check_writes("len0", w, 0);
    endtask

    task automatic test_clamp();
        int w;
        load_random_rom();
        run_check(12, 1'b0, w);
        check_writes("clamp", w, 16);
    endtask

    task automatic test_restart_ignored();
        int w;
        load_pattern_rom();
        run_check(8, 1'b1, w);
        check_writes("restart", w, 16);
    endtask

    task automatic test_mid_reset();
        int w;
        load_random_rom();
        @(posedge clk); #1;
        start = 1'b1; prog_len = 4'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 5; c < 25; c++) begin
            @(negedge clk);
            tests_run++;
            if (ram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== 3'd0 ||
                alu_inst !== 4'd0 || alu_a !== 8'd0 || alu_b !== 8'd0 || ram_waddr !== 4'd0) begin
                tests_failed++;
                $display("FAIL mid_reset cyc=%0d got we=%b busy=%b done=%b rom=%0d waddr=%0d exp all zero",
                         c, ram_we, busy, done, rom_addr, ram_waddr);
            end
            @(posedge clk); #1;
        end
        run_check(3, 1'b0, w);
        check_writes("after_reset", w, 6);
    endtask

    task automatic test_random();
        int w;
        int plen;
        for (int r = 0; r < 6; r++) begin
            load_random_rom();
            plen = $urandom_range(0, 15);
            run_check(plen, 1'b0, w);
            check_writes("random", w, 2 * ((plen > 8) ? 8 : plen));
        end
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_len1();
        test_len0();
        test_clamp();
        test_restart_ignored();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
